// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, bubble encoding and fetch FSM states
package cpu_pkg;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam logic [DEF_INST_W-1:0] BUBBLE_INSTR = 32'h0;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous prefetch FIFO; clear beats push and pop
module fetch_queue #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] head,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr] <= push_data;
    end

    // The fetch credit scheme guarantees a slot for every outstanding read.
    assert property (@(posedge clk) disable iff (rst) !(push && full && !pop && !clear));
endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch: PC, imem req/ack, prefetch queue, IF/ID register
module if_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = DEF_ADDR_W,
    parameter int                INST_W   = DEF_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                QDEPTH   = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_addr,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_rdata,
    output logic [INST_W-1:0] instruction,
    output logic [ADDR_W-1:0] pc_out,
    output logic              valid_out
);
    localparam int CNT_W = $clog2(QDEPTH) + 1;
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);
    localparam logic [INST_W-1:0] BUBBLE  = INST_W'(BUBBLE_INSTR);

    fetch_state_t        state;
    logic [ADDR_W-1:0]   fetch_pc;
    logic [ADDR_W-1:0]   drain_target;
    logic [ADDR_W-1:0]   pc_plus4;

    logic                ack_fire;
    logic                q_push;
    logic                q_pop;
    logic                q_clear;
    logic                q_empty;
    logic                bypass;
    logic                issue_ok;
    logic [CNT_W-1:0]    q_count;
    logic [CNT_W:0]      count_next;
    logic [INST_W-1:0]   head_instr;
    logic [ADDR_W-1:0]   head_pc;

    // fetch_pc doubles as the request address; it only moves on ack or redirect.
    assign imem_addr = fetch_pc;
    assign pc_plus4  = fetch_pc + PC_STEP;
    assign ack_fire  = imem_req && imem_ack;

    always_comb begin
        q_clear  = branch_taken;
        q_pop    = !branch_taken && !freeze && !q_empty;
        bypass   = !branch_taken && !freeze && q_empty && ack_fire && (state == ST_FETCH);
        q_push   = ack_fire && (state == ST_FETCH) && !branch_taken && !bypass;
        count_next = {1'b0, q_count};
        if (q_clear) begin
            count_next = '0;
        end else begin
            if (q_push) count_next = count_next + 1'b1;
            if (q_pop)  count_next = count_next - 1'b1;
        end
        issue_ok = (count_next < (CNT_W + 1)'(QDEPTH));
    end

    fetch_queue #(
        .WIDTH (INST_W + ADDR_W),
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .rst       (rst),
        .push      (q_push),
        .push_data ({imem_rdata, pc_plus4}),
        .pop       (q_pop),
        .clear     (q_clear),
        .count     (q_count),
        .head      ({head_instr, head_pc}),
        .empty     (q_empty)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_FETCH;
            fetch_pc     <= RESET_PC;
            drain_target <= '0;
            imem_req     <= 1'b0;
            instruction  <= BUBBLE;
            pc_out       <= '0;
            valid_out    <= 1'b0;
        end else begin
            if (branch_taken) begin
                instruction <= BUBBLE;
                pc_out      <= '0;
                valid_out   <= 1'b0;
            end else if (!freeze) begin
                if (!q_empty) begin
                    instruction <= head_instr;
                    pc_out      <= head_pc;
                    valid_out   <= 1'b1;
                end else if (bypass) begin
                    instruction <= imem_rdata;
                    pc_out      <= pc_plus4;
                    valid_out   <= 1'b1;
                end else begin
                    instruction <= BUBBLE;
                    pc_out      <= '0;
                    valid_out   <= 1'b0;
                end
            end

            case (state)
                ST_FETCH: begin
                    if (branch_taken && imem_req && !imem_ack) begin
                        // The bus read cannot be withdrawn; let it finish and drop it.
                        state        <= ST_DRAIN;
                        drain_target <= branch_addr;
                    end else begin
                        if (branch_taken)  fetch_pc <= branch_addr;
                        else if (ack_fire) fetch_pc <= pc_plus4;
                        if (!imem_req || imem_ack) imem_req <= issue_ok;
                    end
                end
                ST_DRAIN: begin
                    if (branch_taken) drain_target <= branch_addr;
                    if (ack_fire) begin
                        state    <= ST_FETCH;
                        fetch_pc <= branch_taken ? branch_addr : drain_target;
                        imem_req <= 1'b1;
                    end
                end
                default: state <= ST_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - directed self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
    logic        clk;
    logic        rst;
    logic        freeze;
    logic        branch_taken;
    logic [31:0] branch_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc_out;
    logic        valid_out;

    logic        ack_always;
    logic        ack_manual;
    int          tests_run;
    int          tests_failed;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = word_at(imem_addr);
    assign imem_ack   = ack_always | ack_manual;

    if_fetch_unit dut (
        .clk          (clk),
        .rst          (rst),
        .freeze       (freeze),
        .branch_taken (branch_taken),
        .branch_addr  (branch_addr),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instruction  (instruction),
        .pc_out       (pc_out),
        .valid_out    (valid_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Leaves the bench at the negedge of the first cycle after reset release.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        ack_always = 1'b0; ack_manual = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        ack_always = 1'b0; ack_manual = 1'b0;
        #1;
        tests_run++; if (instruction !== 32'h0) begin tests_failed++; $display("FAIL reset_instr got %h want 0", instruction); end
        tests_run++; if (pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc got %h want 0", pc_out); end
        tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL reset_valid got %b want 0", valid_out); end
        tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL reset_req got %b want 0", imem_req); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (imem_req !== 1'b1) begin tests_failed++; $display("FAIL first_req got %b want 1", imem_req); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL first_addr got %h want 0", imem_addr); end
    endtask

    task automatic test_same_cycle_ack();
        do_reset();
        ack_always = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL fast_valid%0d got %b want 1", k, valid_out); end
            tests_run++; if (instruction !== word_at(32'(4 * (k - 1)))) begin tests_failed++; $display("FAIL fast_instr%0d got %h want %h", k, instruction, word_at(32'(4 * (k - 1)))); end
            tests_run++; if (pc_out !== 32'(4 * k)) begin tests_failed++; $display("FAIL fast_pc%0d got %h want %h", k, pc_out, 32'(4 * k)); end
        end
        ack_always = 1'b0;
    endtask

    task automatic test_slow_ack();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * i)) begin tests_failed++; $display("FAIL slow_req%0d got %b/%h want 1/%h", i, imem_req, imem_addr, 32'(4 * i)); end
            @(negedge clk);
            tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL slow_bubble_a%0d got %b want 0", i, valid_out); end
            @(negedge clk);
            tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL slow_bubble_b%0d got %b want 0", i, valid_out); end
            ack_manual = 1'b1;
            @(negedge clk);
            ack_manual = 1'b0;
            tests_run++; if (valid_out !== 1'b1) begin tests_failed++; $display("FAIL slow_valid%0d got %b want 1", i, valid_out); end
            tests_run++; if (instruction !== word_at(32'(4 * i))) begin tests_failed++; $display("FAIL slow_instr%0d got %h want %h", i, instruction, word_at(32'(4 * i))); end
            tests_run++; if (pc_out !== 32'(4 * i + 4)) begin tests_failed++; $display("FAIL slow_pc%0d got %h want %h", i, pc_out, 32'(4 * i + 4)); end
        end
    endtask

    task automatic test_freeze_full();
        do_reset();
        ack_always = 1'b1;
        @(negedge clk);
        freeze = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests_run++; if (instruction !== word_at(32'h0) || pc_out !== 32'h4 || valid_out !== 1'b1) begin tests_failed++; $display("FAIL frz_hold%0d got %h/%h/%b want %h/4/1", k, instruction, pc_out, valid_out, word_at(32'h0)); end
            if (k == 0) begin
                tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin tests_failed++; $display("FAIL frz_req%0d got %b/%h want 1/8", k, imem_req, imem_addr); end
            end else begin
                tests_run++; if (imem_req !== 1'b0) begin tests_failed++; $display("FAIL frz_req%0d got %b want 0", k, imem_req); end
            end
        end
        freeze = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            @(negedge clk);
            tests_run++; if (instruction !== word_at(32'(4 * j)) || pc_out !== 32'(4 * j + 4) || valid_out !== 1'b1) begin tests_failed++; $display("FAIL frz_resume%0d got %h/%h/%b want %h/%h/1", j, instruction, pc_out, valid_out, word_at(32'(4 * j)), 32'(4 * j + 4)); end
            if (j == 1) begin
                tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'hC) begin tests_failed++; $display("FAIL frz_reissue got %b/%h want 1/c", imem_req, imem_addr); end
            end
        end
        ack_always = 1'b0;
    endtask

    task automatic test_branch_drain();
        do_reset();
        branch_taken = 1'b1; branch_addr = 32'h100;
        @(negedge clk);
        branch_taken = 1'b0;
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL drain_hold got %b/%h want 1/0", imem_req, imem_addr); end
        tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL drain_bubble got %b want 0", valid_out); end
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL drain_discard got %b want 0", valid_out); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin tests_failed++; $display("FAIL drain_target got %b/%h want 1/100", imem_req, imem_addr); end
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        tests_run++; if (instruction !== word_at(32'h100) || pc_out !== 32'h104 || valid_out !== 1'b1) begin tests_failed++; $display("FAIL drain_first got %h/%h/%b want %h/104/1", instruction, pc_out, valid_out, word_at(32'h100)); end
    endtask

    task automatic test_branch_freeze();
        do_reset();
        ack_always = 1'b1;
        @(negedge clk);
        freeze = 1'b1; branch_taken = 1'b1; branch_addr = 32'h200;
        @(negedge clk);
        freeze = 1'b0; branch_taken = 1'b0;
        tests_run++; if (instruction !== 32'h0 || pc_out !== 32'h0 || valid_out !== 1'b0) begin tests_failed++; $display("FAIL brfrz_bubble got %h/%h/%b want 0/0/0", instruction, pc_out, valid_out); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin tests_failed++; $display("FAIL brfrz_redirect got %b/%h want 1/200", imem_req, imem_addr); end
        @(negedge clk);
        tests_run++; if (instruction !== word_at(32'h200) || pc_out !== 32'h204 || valid_out !== 1'b1) begin tests_failed++; $display("FAIL brfrz_first got %h/%h/%b want %h/204/1", instruction, pc_out, valid_out, word_at(32'h200)); end
        ack_always = 1'b0;
    endtask

    task automatic test_pc_wrap();
        do_reset();
        ack_always = 1'b1; branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFC;
        @(negedge clk);
        branch_taken = 1'b0;
        tests_run++; if (imem_addr !== 32'hFFFF_FFFC || valid_out !== 1'b0) begin tests_failed++; $display("FAIL wrap_redirect got %h/%b want fffffffc/0", imem_addr, valid_out); end
        @(negedge clk);
        tests_run++; if (instruction !== word_at(32'hFFFF_FFFC) || pc_out !== 32'h0 || valid_out !== 1'b1) begin tests_failed++; $display("FAIL wrap_last got %h/%h/%b want %h/0/1", instruction, pc_out, valid_out, word_at(32'hFFFF_FFFC)); end
        tests_run++; if (imem_addr !== 32'h0) begin tests_failed++; $display("FAIL wrap_addr got %h want 0", imem_addr); end
        @(negedge clk);
        tests_run++; if (instruction !== word_at(32'h0) || pc_out !== 32'h4) begin tests_failed++; $display("FAIL wrap_next got %h/%h want %h/4", instruction, pc_out, word_at(32'h0)); end
        ack_always = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests_run++; if (instruction !== 32'h0 || pc_out !== 32'h0 || valid_out !== 1'b0 || imem_req !== 1'b0) begin tests_failed++; $display("FAIL rstmid_outputs got %h/%h/%b/%b want 0/0/0/0", instruction, pc_out, valid_out, imem_req); end
        @(negedge clk);
        rst = 1'b0; ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        tests_run++; if (valid_out !== 1'b0) begin tests_failed++; $display("FAIL rstmid_late_ack got %b want 0", valid_out); end
        tests_run++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin tests_failed++; $display("FAIL rstmid_refetch got %b/%h want 1/0", imem_req, imem_addr); end
        ack_manual = 1'b1;
        @(negedge clk);
        ack_manual = 1'b0;
        tests_run++; if (instruction !== word_at(32'h0) || pc_out !== 32'h4 || valid_out !== 1'b1) begin tests_failed++; $display("FAIL rstmid_first got %h/%h/%b want %h/4/1", instruction, pc_out, valid_out, word_at(32'h0)); end
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1; freeze = 1'b0; branch_taken = 1'b0; branch_addr = '0;
        ack_always = 1'b0; ack_manual = 1'b0;
        test_reset();
        test_same_cycle_ack();
        test_slow_ack();
        test_freeze_full();
        test_branch_drain();
        test_branch_freeze();
        test_pc_wrap();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
